// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-cycle data memory.
// One request in flight at a time; each gets a registered response with an out-of-range flag.
module dmem_arbiter #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          a_rerr,

  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          b_rerr,

  output logic          mem_isLd,
  output logic          mem_isSt,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic          PORT_A = 1'b0;
  localparam logic          PORT_B = 1'b1;
  localparam logic [AW-1:0] LIMIT  = AW'(DEPTH);

  state_t        state;
  state_t        state_nxt;
  logic          last_win;
  logic          cmd_port;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic          grant;
  logic          winner;
  logic          in_range;
  logic [DW-1:0] rsp_data;

  // Arbitration: a tie goes to the port that did not win last time.
  always_comb begin
    grant  = 1'b0;
    winner = PORT_A;
    if (state == IDLE && !rst) begin
      if (a_req && b_req) begin
        grant  = 1'b1;
        winner = (last_win == PORT_B) ? PORT_A : PORT_B;
      end else if (a_req) begin
        grant  = 1'b1;
        winner = PORT_A;
      end else if (b_req) begin
        grant  = 1'b1;
        winner = PORT_B;
      end
    end
  end

  always_comb begin
    a_gnt = grant && (winner == PORT_A);
    b_gnt = grant && (winner == PORT_B);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ACCESS;
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_range = (cmd_addr < LIMIT);
    rsp_data = (in_range && !cmd_we) ? mem_data_out : '0;
  end

  // Enables are masked by rst so a reset landing in ACCESS cannot commit the store.
  always_comb begin
    mem_isLd    = 1'b0;
    mem_isSt    = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    if (state == ACCESS && !rst && in_range) begin
      mem_isLd    = !cmd_we;
      mem_isSt    = cmd_we;
      mem_address = cmd_addr;
      mem_data_in = cmd_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_win <= PORT_B;
    end else begin
      state <= state_nxt;
      if (grant) last_win <= winner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_port  <= PORT_A;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (grant) begin
      cmd_port  <= winner;
      cmd_we    <= (winner == PORT_B) ? b_we    : a_we;
      cmd_addr  <= (winner == PORT_B) ? b_addr  : a_addr;
      cmd_wdata <= (winner == PORT_B) ? b_wdata : a_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
      a_rerr   <= 1'b0;
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
      b_rerr   <= 1'b0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      if (state == ACCESS) begin
        if (cmd_port == PORT_A) begin
          a_rvalid <= 1'b1;
          a_rdata  <= rsp_data;
          a_rerr   <= !in_range;
        end else begin
          b_rvalid <= 1'b1;
          b_rdata  <= rsp_data;
          b_rerr   <= !in_range;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then randomized traffic against a
// transaction-level reference (round-robin owner, shadow memory, expected responses).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rvalid, a_rerr, b_gnt, b_rvalid, b_rerr;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_isLd, mem_isSt;
  logic [31:0] mem_address, mem_data_in, mem_data_out;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(16), .AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_rerr(a_rerr),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_rerr(b_rerr),
    .mem_isLd(mem_isLd), .mem_isSt(mem_isSt), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // Physical memory seen by the DUT; only the initial block writes it.
  logic [31:0] mem [16];
  assign mem_data_out = (mem_address < 32'd16) ? mem[mem_address[3:0]] : 32'd0;

  // Reference model state.
  logic [31:0] ref_mem [16];
  logic        m_busy, m_last_b, m_port, m_we;
  logic [31:0] m_addr, m_wdata;
  logic        m_rv_a, m_rv_b, m_re_a, m_re_b;
  logic [31:0] m_rd_a, m_rd_b;
  logic        eg_a, eg_b;

  // Snapshot of DUT outputs at the most recent sample point.
  logic        s_agnt, s_bgnt, s_arv, s_brv, s_are, s_bre, s_ld, s_st;
  logic [31:0] s_ard, s_brd, s_addr, s_wd;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned st_cycles = 0;
  logic        glog [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_last_b = 1'b1; m_port = 1'b0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0;
    m_rv_a = 1'b0; m_rv_b = 1'b0; m_re_a = 1'b0; m_re_b = 1'b0;
    m_rd_a = '0; m_rd_b = '0;
  endtask

  // One clock cycle: check at the falling edge, then advance memory and model past the rising edge.
  task automatic tick();
    logic in_rng;
    logic [31:0] d;
    @(negedge clk);
    eg_a = 1'b0; eg_b = 1'b0;
    if (!rst && !m_busy) begin
      if (a_req && b_req) begin
        eg_a = m_last_b; eg_b = !m_last_b;
      end else begin
        eg_a = a_req; eg_b = b_req;
      end
    end
    in_rng = (m_addr < 32'd16);
    s_agnt = a_gnt; s_bgnt = b_gnt; s_arv = a_rvalid; s_brv = b_rvalid;
    s_ard = a_rdata; s_brd = b_rdata; s_are = a_rerr; s_bre = b_rerr;
    s_ld = mem_isLd; s_st = mem_isSt; s_addr = mem_address; s_wd = mem_data_in;
    chk("a_gnt", a_gnt, eg_a);
    chk("b_gnt", b_gnt, eg_b);
    chk("a_rvalid", a_rvalid, m_rv_a);
    chk("b_rvalid", b_rvalid, m_rv_b);
    chk("a_rdata", a_rdata, m_rd_a);
    chk("b_rdata", b_rdata, m_rd_b);
    chk("a_rerr", a_rerr, m_re_a);
    chk("b_rerr", b_rerr, m_re_b);
    chk("mem_isSt", mem_isSt, m_busy && !rst && in_rng && m_we);
    if (!rst) chk("mem_isLd", mem_isLd, m_busy && in_rng && !m_we);
    if (!m_busy) begin
      chk("mem_address_idle", mem_address, 32'd0);
      chk("mem_data_in_idle", mem_data_in, 32'd0);
    end else if (!rst && in_rng) begin
      chk("mem_address", mem_address, m_addr);
      chk("mem_data_in", mem_data_in, m_wdata);
    end
    if (a_gnt) glog.push_back(1'b0);
    if (b_gnt) glog.push_back(1'b1);
    if (mem_isSt) st_cycles++;
    @(posedge clk);
    #1;
    if (s_st && s_addr < 32'd16) mem[s_addr[3:0]] = s_wd;
    if (rst) begin
      model_reset();
    end else begin
      m_rv_a = 1'b0; m_rv_b = 1'b0;
      if (m_busy) begin
        d = (in_rng && !m_we) ? ref_mem[m_addr[3:0]] : 32'd0;
        if (in_rng && m_we) ref_mem[m_addr[3:0]] = m_wdata;
        if (m_port) begin m_rv_b = 1'b1; m_rd_b = d; m_re_b = !in_rng; end
        else        begin m_rv_a = 1'b1; m_rd_a = d; m_re_a = !in_rng; end
        m_busy = 1'b0;
      end else if (eg_a || eg_b) begin
        m_busy = 1'b1; m_port = eg_b; m_last_b = eg_b;
        m_we    = eg_b ? b_we    : a_we;
        m_addr  = eg_b ? b_addr  : a_addr;
        m_wdata = eg_b ? b_wdata : a_wdata;
      end
    end
  endtask

  initial begin
    logic [31:0] v;
    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    model_reset();
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      mem[i] = v; ref_mem[i] = v;
    end
    mem[10] = 32'd9;          ref_mem[10] = 32'd9;
    mem[5]  = 32'hA5A5_0005;  ref_mem[5]  = 32'hA5A5_0005;

    // Reset state
    tick(); tick();
    chk("rst_a_rdata", s_ard, 32'd0);
    chk("rst_b_rvalid", s_brv, 1'b0);
    rst = 1'b0;

    // Load from word 10
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd10;
    tick();
    chk("t1_a_gnt", s_agnt, 1'b1);
    a_req = 1'b0;
    tick();
    chk("t1_isLd", s_ld, 1'b1);
    chk("t1_addr", s_addr, 32'd10);
    tick();
    chk("t1_a_rvalid", s_arv, 1'b1);
    chk("t1_a_rdata", s_ard, 32'd9);
    chk("t1_a_rerr", s_are, 1'b0);
    chk("t1_b_rvalid", s_brv, 1'b0);

    // Port B store then load back
    st_cycles = 0;
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'd3; b_wdata = 32'hDEAD_BEEF;
    tick();
    b_req = 1'b0;
    tick(); tick();
    b_req = 1'b1; b_we = 1'b0;
    tick();
    b_req = 1'b0;
    tick(); tick();
    chk("t2_b_rvalid", s_brv, 1'b1);
    chk("t2_b_rdata", s_brd, 32'hDEAD_BEEF);
    chk("t2_st_cycles", st_cycles, 32'd1);

    // Both ports held: alternating grants starting with A after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    glog.delete();
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'd2;
    for (int c = 0; c < 8; c++) tick();
    a_req = 1'b0; b_req = 1'b0;
    chk("t3_grants", glog.size(), 32'd4);
    for (int g = 0; g < 4 && g < glog.size(); g++)
      chk($sformatf("t3_grant%0d", g), glog[g], g % 2);
    tick(); tick();

    // Out-of-range load
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd20;
    tick();
    a_req = 1'b0;
    tick();
    chk("t4_isLd", s_ld, 1'b0);
    chk("t4_isSt", s_st, 1'b0);
    tick();
    chk("t4_a_rvalid", s_arv, 1'b1);
    chk("t4_a_rerr", s_are, 1'b1);
    chk("t4_a_rdata", s_ard, 32'd0);

    // Reset during a store's ACCESS cycle
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'd5; a_wdata = 32'h1234_5678;
    tick();
    a_req = 1'b0;
    rst = 1'b1;
    tick();
    chk("t5_isSt", s_st, 1'b0);
    rst = 1'b0;
    tick();
    chk("t5_no_rvalid", s_arv, 1'b0);
    a_req = 1'b1; a_we = 1'b0;
    tick();
    chk("t5_idle_gnt", s_agnt, 1'b1);
    a_req = 1'b0;
    tick(); tick();
    chk("t5_word_kept", s_ard, 32'hA5A5_0005);

    // Request raised in the previous response cycle is granted immediately
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd1;
    tick();
    a_req = 1'b0;
    tick();
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'd2;
    tick();
    chk("t6_a_rvalid", s_arv, 1'b1);
    chk("t6_b_gnt", s_bgnt, 1'b1);
    b_req = 1'b0;
    tick(); tick();
    chk("t6_b_rvalid", s_brv, 1'b1);

    // Randomized traffic with requests held until granted
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      tick();
      if (eg_a || !a_req) begin
        if ($urandom_range(0, 2) != 0) begin
          a_req = 1'b1; a_we = $urandom_range(0, 1);
          a_addr = $urandom_range(0, 19); a_wdata = $urandom;
        end else a_req = 1'b0;
      end
      if (eg_b || !b_req) begin
        if ($urandom_range(0, 2) != 0) begin
          b_req = 1'b1; b_we = $urandom_range(0, 1);
          b_addr = $urandom_range(0, 19); b_wdata = $urandom;
        end else b_req = 1'b0;
      end
    end
    rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
    tick(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
